// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt controller at the M stage
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL   = 32'h2023_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] M_PC,
    input  logic [4:0]  M_ExcCode,
    input  logic        M_BD,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC,
    output logic        Req
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_sel;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        unused_pc_low;

    // Request decision: any enabled pending interrupt or a faulting M instruction, masked by EXL.
    always_comb begin
        int_req = ie_q & ~exl_q & (|(HWInt & im_q));
        exc_req = (M_ExcCode != 5'd0) & ~exl_q;
        Req     = ~reset & (int_req | exc_req);
    end

    // Delay-slot instructions restart at the branch, so EPC backs up one word.
    assign pc_sel        = M_BD ? (M_PC - 32'd4) : M_PC;
    assign unused_pc_low = ^pc_sel[1:0];

    // Next-state: a taken request owns the edge; otherwise mtc0 beats eret.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (Req) begin
            exl_d      = 1'b1;
            bd_d       = M_BD;
            exc_code_d = int_req ? 5'd0 : M_ExcCode;
            epc_d      = {pc_sel[31:2], 2'b00};
        end else if (WE) begin
            if (A == REG_SR) begin
                im_d  = DIn[15:10];
                exl_d = DIn[1];
                ie_d  = DIn[0];
            end else if (A == REG_EPC) begin
                epc_d = {DIn[31:2], 2'b00};
            end
        end else if (EXLClr) begin
            exl_d = 1'b0;
        end
    end

    // CP0 state registers; IP samples the interrupt lines every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= HWInt;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};

    // Read mux reflects pre-edge register state.
    always_comb begin
        DOut = 32'd0;
        case (A)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

    assign EPCOut    = epc_q;
    assign HandlerPC = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] M_PC;
    logic [4:0]  M_ExcCode;
    logic        M_BD;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    logic        Req;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_exc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .DIn       (DIn),
        .WE        (WE),
        .M_PC      (M_PC),
        .M_ExcCode (M_ExcCode),
        .M_BD      (M_BD),
        .EXLClr    (EXLClr),
        .HWInt     (HWInt),
        .DOut      (DOut),
        .EPCOut    (EPCOut),
        .HandlerPC (HandlerPC),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        A = addr;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic chk_req(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, Req}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1; A = 5'd0; DIn = 32'd0; WE = 1'b0; M_PC = 32'd0;
        M_ExcCode = 5'd0; M_BD = 1'b0; EXLClr = 1'b0; HWInt = 6'd0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h2023_0007);
        rd("rst_other", 5'd3, 32'h0);
        check("rst_epcout", EPCOut, 32'h0);
        check("handler_pc", HandlerPC, 32'h0000_4180);
        chk_req("rst_req", 1'b0);

        // enable IM[10] and IE
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0;
        rd("mtc0_sr", 5'd12, 32'h0000_0401);

        // interrupt taken
        HWInt = 6'b000001; M_PC = 32'h0000_3010; M_BD = 1'b0;
        chk_req("int_req", 1'b1);
        tick();
        rd("int_sr", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h0000_3010);
        chk_req("int_req_masked", 1'b0);

        // masking under EXL
        M_ExcCode = 5'd12;
        chk_req("mask_req", 1'b0);
        tick();
        rd("mask_sr", 5'd12, 32'h0000_0403);
        rd("mask_epc", 5'd14, 32'h0000_3010);
        rd("mask_cause", 5'd13, 32'h0000_0400);
        M_ExcCode = 5'd0; EXLClr = 1'b1;
        chk_req("eret_req", 1'b0);
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk_req("reappear_req", 1'b1);
        HWInt = 6'd0;
        chk_req("int_gone_req", 1'b0);
        tick();

        // exception in delay slot
        M_ExcCode = 5'd4; M_BD = 1'b1; M_PC = 32'h0000_3024;
        chk_req("exc_req", 1'b1);
        tick();
        M_ExcCode = 5'd0; M_BD = 1'b0;
        rd("exc_epc", 5'd14, 32'h0000_3020);
        rd("exc_cause", 5'd13, 32'h8000_0010);
        rd("exc_sr", 5'd12, 32'h0000_0403);

        // priority and drop of simultaneous mtc0
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        HWInt = 6'b000001; M_ExcCode = 5'd10; WE = 1'b1; A = 5'd14;
        DIn = 32'hDEAD_BEEF; M_PC = 32'h0000_3040;
        chk_req("prio_req", 1'b1);
        tick();
        WE = 1'b0; M_ExcCode = 5'd0;
        rd("prio_epc", 5'd14, 32'h0000_3040);
        rd("prio_cause", 5'd13, 32'h0000_0400);

        // mtc0 EPC alignment, no write-through
        WE = 1'b1; A = 5'd14; DIn = 32'h0000_3007;
        #1;
        check("epc_no_bypass", DOut, 32'h0000_3040);
        tick();
        check("epc_align_out", EPCOut, 32'h0000_3004);
        rd("epc_align_rd", 5'd14, 32'h0000_3004);
        A = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0;
        rd("cause_wr_ignored", 5'd13, 32'h0000_0400);

        // EPC wraparound with delay slot
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; HWInt = 6'd0;
        M_ExcCode = 5'd8; M_BD = 1'b1; M_PC = 32'h0000_0002;
        chk_req("wrap_req", 1'b1);
        tick();
        M_ExcCode = 5'd0; M_BD = 1'b0;
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0020);

        // reset beats a simultaneous request
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        M_ExcCode = 5'd9; M_PC = 32'h0000_5000;
        chk_req("pre_rst_req", 1'b1);
        reset = 1'b1;
        chk_req("rst_wins_req", 1'b0);
        tick();
        reset = 1'b0; M_ExcCode = 5'd0;
        rd("rst_wins_epc", 5'd14, 32'h0);
        rd("rst_wins_sr", 5'd12, 32'h0);
        rd("rst_wins_cause", 5'd13, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
